// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB master bridge:
//   - apb_state_t   : bridge FSM state encoding (IDLE/SETUP/ACCESS/RESP)
//   - PPROT_*_BIT   : bit positions inside PPROT
//   - PPROT_WIDTH   : width of the protection field
//   - ctr_width()   : width of the ACCESS wait-state counter for a TIMEOUT
// The command record itself depends on the address/data width parameters,
// so its packed struct is declared inside the bridge from these pieces.
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_t;

   // PPROT[0] privileged, PPROT[1] non-secure, PPROT[2] instruction access
   localparam int unsigned PPROT_PRIV_BIT   = 0;
   localparam int unsigned PPROT_NONSEC_BIT = 1;
   localparam int unsigned PPROT_INSTR_BIT  = 2;
   localparam int unsigned PPROT_WIDTH      = 3;

   // Counter must be able to hold TIMEOUT; keep at least one bit so the
   // disabled (TIMEOUT=0) configuration still has a legal vector width.
   function automatic int unsigned ctr_width(input int unsigned timeout);
      if (timeout == 0) begin
         return 1;
      end
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// apb_timeout_ctr
// Counts ACCESS-phase wait cycles and flags the cycle in which the transfer
// must be abandoned.
// Ports:
//   i_clk      clock, rising edge
//   i_srst     synchronous active-high reset
//   i_clear    zero the count (asserted the cycle before ACCESS begins)
//   i_enable   an ACCESS cycle without PREADY; counts and qualifies expiry
//   o_expired  high in the TIMEOUT-th consecutive wait cycle (combinational
//              from the count and i_enable; consumed by the bridge FSM only)
// TIMEOUT = 0 removes the counter and never expires.
// -----------------------------------------------------------------------------
module apb_timeout_ctr
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic i_clk,
   input  logic i_srst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   generate
      if (TIMEOUT == 0) begin : g_disabled
         assign o_expired = 1'b0;
      end else begin : g_enabled
         localparam int unsigned          CW   = ctr_width(TIMEOUT);
         // The count holds the number of wait cycles already completed, so
         // the current cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
         localparam logic [CW-1:0]        LAST = CW'(TIMEOUT - 1);

         logic [CW-1:0] r_count;

         always_ff @(posedge i_clk) begin
            if (i_srst || i_clear) begin
               r_count <= '0;
            end else if (i_enable) begin
               r_count <= r_count + 1'b1;
            end
         end

         assign o_expired = i_enable && (r_count == LAST);
      end
   endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// APB4 requester: turns one valid/ready command into a SETUP/ACCESS transfer
// and returns one valid/ready response. One transfer outstanding at a time.
// Parameters:
//   ADDR_WIDTH  PADDR / cmd_addr width
//   DATA_WIDTH  PWDATA / PRDATA width (8, 16 or 32); strobes are DATA_WIDTH/8
//   TIMEOUT     max ACCESS cycles without PREADY before an error response;
//               0 waits forever
// Ports:
//   PCLK, PRESET                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_write/addr/wdata/strb/prot command fields, captured on accept
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata/rsp_err/rsp_timeout response fields, stable while rsp_valid
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT  APB requester outputs
//   PREADY/PSLVERR/PRDATA                         APB completer inputs
// Every output is a register, so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module apb_master_bridge
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   // command channel
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_write,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
   input  logic [PPROT_WIDTH-1:0]    cmd_prot,
   // response channel
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err,
   output logic                      rsp_timeout,
   // APB requester
   output logic                      PSEL,
   output logic                      PENABLE,
   output logic                      PWRITE,
   output logic [ADDR_WIDTH-1:0]     PADDR,
   output logic [DATA_WIDTH-1:0]     PWDATA,
   output logic [DATA_WIDTH/8-1:0]   PSTRB,
   output logic [PPROT_WIDTH-1:0]    PPROT,
   input  logic                      PREADY,
   input  logic                      PSLVERR,
   input  logic [DATA_WIDTH-1:0]     PRDATA
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   typedef struct packed {
      logic                   write;
      logic [ADDR_WIDTH-1:0]  addr;
      logic [DATA_WIDTH-1:0]  wdata;
      logic [STRB_WIDTH-1:0]  strb;
      logic [PPROT_WIDTH-1:0] prot;
   } cmd_t;

   apb_state_t              r_state;
   cmd_t                    r_cmd;
   logic                    r_cmd_ready;
   logic                    r_psel;
   logic                    r_penable;
   logic                    r_rsp_valid;
   logic [DATA_WIDTH-1:0]   r_rsp_rdata;
   logic                    r_rsp_err;
   logic                    r_rsp_timeout;

   logic [STRB_WIDTH-1:0]   w_strb_eff;
   cmd_t                    w_cmd_in;
   logic                    w_ctr_clear;
   logic                    w_ctr_en;
   logic                    w_expired;

   // Reads never drive byte strobes; masking happens at capture so the
   // registered PSTRB is already correct from the first SETUP cycle.
   genvar gi;
   generate
      for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_strb
         assign w_strb_eff[gi] = cmd_write & cmd_strb[gi];
      end
   endgenerate

   always_comb begin
      w_cmd_in       = '0;
      w_cmd_in.write = cmd_write;
      w_cmd_in.addr  = cmd_addr;
      w_cmd_in.wdata = cmd_wdata;
      w_cmd_in.strb  = w_strb_eff;
      w_cmd_in.prot  = cmd_prot;
   end

   // The counter is zeroed during SETUP so it starts from 0 in the first
   // ACCESS cycle, and it only advances while the completer is stalling.
   assign w_ctr_clear = (r_state == ST_SETUP);
   assign w_ctr_en    = (r_state == ST_ACCESS) && !PREADY;

   apb_timeout_ctr #(
      .TIMEOUT   (TIMEOUT)
   ) u_timeout_ctr (
      .i_clk     (PCLK),
      .i_srst    (PRESET),
      .i_clear   (w_ctr_clear),
      .i_enable  (w_ctr_en),
      .o_expired (w_expired)
   );

   // Bridge FSM. All handshake and APB control outputs are registered here
   // alongside the state so they change on the same edge as the state.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state       <= ST_IDLE;
         r_cmd         <= '0;
         r_cmd_ready   <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_err     <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // r_cmd_ready is low for the first cycle after reset, so the
               // accept is qualified by it rather than by the state alone.
               if (r_cmd_ready && cmd_valid) begin
                  r_state     <= ST_SETUP;
                  r_cmd       <= w_cmd_in;
                  r_cmd_ready <= 1'b0;
                  r_psel      <= 1'b1;
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end

            ST_SETUP: begin
               r_state   <= ST_ACCESS;
               r_penable <= 1'b1;
            end

            ST_ACCESS: begin
               // PREADY is tested first so a completion in the final
               // allowed cycle yields a normal response, not a timeout.
               if (PREADY) begin
                  r_state       <= ST_RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= r_cmd.write ? '0 : PRDATA;
                  r_rsp_err     <= PSLVERR;
                  r_rsp_timeout <= 1'b0;
               end else if (w_expired) begin
                  r_state       <= ST_RESP;
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
               end
            end

            default: begin
               r_state     <= ST_IDLE;
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_err     = r_rsp_err;
   assign rsp_timeout = r_rsp_timeout;

   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_cmd.write;
   assign PADDR       = r_cmd.addr;
   assign PWDATA      = r_cmd.wdata;
   assign PSTRB       = r_cmd.strb;
   assign PPROT       = r_cmd.prot;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge (32-bit address/data, TIMEOUT=4).
// A directed vector table, randomized transfers scored against a transfer-
// level model, and hand-written reset sequences.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;
   import apb_pkg::*;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int TO = 4;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [SW-1:0] cmd_strb;
   logic [2:0]    cmd_prot;
   logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [DW-1:0] rsp_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [SW-1:0] PSTRB;
   logic [2:0]    PPROT;

   always #5 PCLK = ~PCLK;

   apb_master_bridge #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TO)
   ) dut (
      .PCLK        (PCLK),
      .PRESET      (PRESET),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_write   (cmd_write),
      .cmd_addr    (cmd_addr),
      .cmd_wdata   (cmd_wdata),
      .cmd_strb    (cmd_strb),
      .cmd_prot    (cmd_prot),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rsp_timeout (rsp_timeout),
      .PSEL        (PSEL),
      .PENABLE     (PENABLE),
      .PWRITE      (PWRITE),
      .PADDR       (PADDR),
      .PWDATA      (PWDATA),
      .PSTRB       (PSTRB),
      .PPROT       (PPROT),
      .PREADY      (PREADY),
      .PSLVERR     (PSLVERR),
      .PRDATA      (PRDATA)
   );

   // One transfer: stimulus plus the expected response.
   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          waits;      // cycles PREADY stays low before it rises
      logic [31:0] prdata;
      logic        slverr;
      int          rsp_delay;  // cycles rsp_ready is held low
      int          exp_access; // ACCESS cycles the transfer must take
      logic        exp_err;
      logic        exp_to;
      logic [31:0] exp_rdata;
   } vec_t;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st, input logic [2:0] pr, input int w,
                               input logic [31:0] rd, input logic se, input int dly,
                               input int ea, input logic ee, input logic et,
                               input logic [31:0] er);
      vec_t v;
      v.write = wr; v.addr = a; v.wdata = wd; v.strb = st; v.prot = pr;
      v.waits = w; v.prdata = rd; v.slverr = se; v.rsp_delay = dly;
      v.exp_access = ea; v.exp_err = ee; v.exp_to = et; v.exp_rdata = er;
      return v;
   endfunction

   // Transfer-level reference: a completer that stalls `waits` cycles is
   // given up on once TIMEOUT wait cycles have elapsed without PREADY.
   function automatic vec_t model(input vec_t v_in);
      vec_t v;
      logic timed;
      v = v_in;
      timed        = (TO != 0) && (v.waits >= TO);
      v.exp_access = timed ? TO : v.waits + 1;
      v.exp_to     = timed;
      v.exp_err    = timed || v.slverr;
      v.exp_rdata  = (timed || v.write) ? 32'h0 : v.prdata;
      return v;
   endfunction

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   // Drive one command, play the completer, check the APB pins and response.
   task automatic run_xfer(input vec_t v, input string tag);
      logic        accepted, pins_ok, seq_ok, hold_ok;
      logic [3:0]  exp_strb;
      int          k, acc;
      exp_strb  = v.write ? v.strb : 4'h0;
      cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
      cmd_strb  = v.strb;  cmd_prot = v.prot; cmd_valid = 1'b1;
      accepted  = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (cmd_ready) begin
            accepted = 1'b1;
            tick();
            break;
         end
         tick();
      end
      cmd_valid = 1'b0;
      // Scramble the command bus: the DUT must hold its own copy.
      cmd_write = $urandom_range(0, 1); cmd_addr = $urandom; cmd_wdata = $urandom;
      cmd_strb  = 4'($urandom); cmd_prot = 3'($urandom);
      check({tag, "_accept"}, 32'(accepted), 32'h1);
      if (!accepted) return;

      check({tag, "_setup_psel_penable"}, {30'h0, PSEL, PENABLE}, 32'h2);
      pins_ok = (PADDR === v.addr) && (PWRITE === v.write) && (PWDATA === v.wdata) &&
                (PSTRB === exp_strb) && (PPROT === v.prot);
      seq_ok  = 1'b1;
      acc     = 0;
      k       = 1;
      while (PSEL === 1'b1 && k < 40) begin
         tick();
         k++;
         PREADY  = 1'b0;
         PSLVERR = 1'($urandom);   // must be ignored without PREADY
         PRDATA  = $urandom;
         if (PSEL === 1'b1) begin
            if (PENABLE !== 1'b1) seq_ok = 1'b0;
            acc++;
            pins_ok &= (PADDR === v.addr) && (PWRITE === v.write) && (PWDATA === v.wdata) &&
                       (PSTRB === exp_strb) && (PPROT === v.prot);
            if (acc == v.waits + 1) begin
               PREADY  = 1'b1;
               PSLVERR = v.slverr;
               PRDATA  = v.prdata;
            end
         end else begin
            PSLVERR = 1'b0;
         end
      end
      PREADY = 1'b0; PSLVERR = 1'b0;

      check({tag, "_access_cycles"}, 32'(acc), 32'(v.exp_access));
      check({tag, "_rsp_latency"}, 32'(k), 32'(2 + v.exp_access));
      check({tag, "_penable_seq"}, 32'(seq_ok), 32'h1);
      check({tag, "_pins_stable"}, 32'(pins_ok), 32'h1);
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
      check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
      check({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_to));
      check({tag, "_cmd_ready_busy"}, 32'(cmd_ready), 32'h0);

      if (v.rsp_delay > 0) begin
         hold_ok = 1'b1;
         for (int d = 0; d < v.rsp_delay; d++) begin
            tick();
            hold_ok &= (rsp_valid === 1'b1) && (rsp_rdata === v.exp_rdata) &&
                       (rsp_err === v.exp_err) && (rsp_timeout === v.exp_to) &&
                       (cmd_ready === 1'b0) && (PSEL === 1'b0);
         end
         check({tag, "_backpressure_hold"}, 32'(hold_ok), 32'h1);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, "_rsp_done_ready"}, {30'h0, rsp_valid, cmd_ready}, 32'h1);
      $display("xfer %s: %s addr=0x%08h waits=%0d access=%0d rdata=0x%08h err=%0b to=%0b",
               tag, v.write ? "WR" : "RD", v.addr, v.waits, acc, rsp_rdata, rsp_err, rsp_timeout);
   endtask

   // Watchdog: a hung DUT must still end the run.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[8];
   vec_t rv;

   initial begin
      //          wr  addr         wdata         strb  prot    waits prdata        slv dly | acc err to  rdata
      tbl[0] = mk(1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 32'h0,        0, 0,   1, 0, 0, 32'h0);
      tbl[1] = mk(0, 32'h20, 32'h0,        4'hF, 3'b000, 3, 32'h12345678, 0, 0,   4, 0, 0, 32'h12345678);
      tbl[2] = mk(1, 32'h24, 32'hCAFEF00D, 4'h3, 3'b001, 0, 32'h0,        1, 0,   1, 1, 0, 32'h0);
      tbl[3] = mk(0, 32'h30, 32'h0,        4'hF, 3'b010, 9, 32'h55AA55AA, 1, 0,   4, 1, 1, 32'h0);
      tbl[4] = mk(0, 32'h34, 32'h0,        4'h5, 3'b000, 3, 32'h0BADC0DE, 0, 1,   4, 0, 0, 32'h0BADC0DE);
      tbl[5] = mk(0, 32'h38, 32'h0,        4'hF, 3'b100, 1, 32'hAABBCCDD, 1, 0,   2, 1, 0, 32'hAABBCCDD);
      tbl[6] = mk(1, 32'h3C, 32'h01020304, 4'hC, 3'b111, 9, 32'h0,        0, 5,   4, 1, 1, 32'h0);
      tbl[7] = mk(0, 32'h40, 32'h0,        4'h0, 3'b000, 2, 32'hFEEDFACE, 0, 5,   3, 0, 0, 32'hFEEDFACE);

      PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;

      // Reset state while PRESET is held.
      repeat (3) tick();
      check("rst_cmd_ready", 32'(cmd_ready), 32'h0);
      check("rst_rsp", {28'h0, rsp_valid, rsp_err, rsp_timeout, 1'b0}, 32'h0);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_psel_penable_pwrite", {29'h0, PSEL, PENABLE, PWRITE}, 32'h0);
      check("rst_paddr", PADDR, 32'h0);
      check("rst_pwdata", PWDATA, 32'h0);
      check("rst_pstrb_pprot", {25'h0, PSTRB, PPROT}, 32'h0);
      PRESET = 1'b0;
      tick();
      check("rst_release_cmd_ready", 32'(cmd_ready), 32'h1);

      for (int i = 0; i < 8; i++) begin
         run_xfer(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset asserted during ACCESS abandons the transfer.
      cmd_write = 1'b0; cmd_addr = 32'h80; cmd_strb = 4'hF; cmd_prot = 3'b000;
      cmd_valid = 1'b1;
      check("rr_ready_before", 32'(cmd_ready), 32'h1);
      tick();                       // accepted; now SETUP
      cmd_valid = 1'b0;
      tick();                       // ACCESS, completer stalls
      check("rr_in_access", {30'h0, PSEL, PENABLE}, 32'h3);
      PRESET = 1'b1;
      tick();
      check("rr_reset_outputs", {28'h0, PSEL, PENABLE, rsp_valid, cmd_ready}, 32'h0);
      PRESET = 1'b0;
      tick();
      check("rr_release_ready", {29'h0, cmd_ready, PSEL, rsp_valid}, 32'h4);
      repeat (3) tick();
      check("rr_no_response", {30'h0, rsp_valid, PSEL}, 32'h0);

      // Randomized transfers scored against the model.
      for (int i = 0; i < 40; i++) begin
         rv = mk(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
                 int'($urandom_range(0, 6)), $urandom, 1'($urandom),
                 int'($urandom_range(0, 3)), 0, 1'b0, 1'b0, 32'h0);
         rv = model(rv);
         run_xfer(rv, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
